mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one keyed-mux datapath (MuxKey-style N:1 select) between NR_REQ requesters.
- Grants one requester per transfer and registers the selected data and source index into a single output slot with valid/ready handshake.
- Supports locked bursts: a requester keeps ownership until it presents its last beat.
- Sits between several producer blocks and one shared consumer.

---
 rtl/mux_rr_arbiter_if.sv | 34 +++
 rtl/mux_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// mux_rr_arbiter_if : requester / consumer bundle around the shared datapath
// Revision: 1.0
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int NR_REQ   = 4,
    parameter int DATA_LEN = 8,
    parameter int SEL_LEN  = 2
);
    logic [NR_REQ-1:0]          req_valid;
    logic [NR_REQ-1:0]          req_last;
    logic [NR_REQ*DATA_LEN-1:0] req_data;
    logic [NR_REQ-1:0]          req_ready;
    logic                       out_valid;
    logic [DATA_LEN-1:0]        out_data;
    logic [SEL_LEN-1:0]         out_src;
    logic                       out_last;
    logic                       out_ready;
    logic                       busy;

    // Producer/consumer side
    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, out_last, busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux_rr_arbiter : round-robin arbiter with locked bursts feeding one output slot
// Revision: 1.0
// ============================================================================
module mux_rr_arbiter #(
    parameter int NR_REQ   = 4,
    parameter int DATA_LEN = 8,
    parameter int SEL_LEN  = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux_rr_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    logic [SEL_LEN-1:0]  ptr_q;
    logic [SEL_LEN-1:0]  owner_q;
    logic                busy_q;
    logic                out_valid_q;
    logic [DATA_LEN-1:0] out_data_q;
    logic [SEL_LEN-1:0]  out_src_q;
    logic                out_last_q;

    logic [DATA_LEN-1:0] slice [NR_REQ];
    logic [SEL_LEN-1:0]  win;
    logic [SEL_LEN-1:0]  cand;
    logic [SEL_LEN-1:0]  ptr_d;
    logic                found;
    logic                load_en;
    logic                xfer;
    logic                win_last;
    logic [DATA_LEN-1:0] sel_data;
    logic [NR_REQ-1:0]   ready;
    int                  sum;

    generate
        for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_slice
            assign slice[gi] = bus.req_data[DATA_LEN*gi +: DATA_LEN];
        end
    endgenerate

    // Descending scan: the last hit written is the one closest to ptr_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        sum   = 0;
        if (state_q == ST_LOCKED) begin
            win   = owner_q;
            found = bus.req_valid[owner_q];
        end else begin
            for (int k = NR_REQ - 1; k >= 0; k--) begin
                sum = int'(ptr_q) + k;
                if (sum >= NR_REQ) begin
                    sum = sum - NR_REQ;
                end
                cand = SEL_LEN'(sum);
                if (bus.req_valid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign xfer    = load_en && found && !rst;
    assign ready   = xfer ? (NR_REQ'(1) << win) : '0;
    assign ptr_d   = (win == SEL_LEN'(NR_REQ - 1)) ? '0 : win + SEL_LEN'(1);

    // Keyed AND-OR mux; yields zero when nobody wins.
    always_comb begin
        sel_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (found && (win == SEL_LEN'(i))) begin
                sel_data = sel_data | slice[i];
                win_last = bus.req_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_src_q   <= win;
                out_last_q  <= win_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        if (win_last) begin
                            ptr_q <= ptr_d;
                        end else begin
                            state_q <= ST_LOCKED;
                            owner_q <= win;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (xfer && win_last) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_arbiter : scoreboard bench for the round-robin arbiter
// Revision: 1.0
// ============================================================================
module tb_mux_rr_arbiter;
    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic  clk;
    logic  rst;
    int    total;
    int    bad;
    beat_t sb [$];

    mux_rr_arbiter_if #(.NR_REQ(4), .DATA_LEN(8), .SEL_LEN(2)) bus ();

    mux_rr_arbiter #(.NR_REQ(4), .DATA_LEN(8), .SEL_LEN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, check ready/busy, queue the expected beat.
    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       input logic [3:0] exp_rdy, input logic exp_busy, input string nm);
        beat_t b;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.out_ready = rdy;
        #2;
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        chk({nm, "_busy"}, 32'(bus.busy), 32'(exp_busy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                b.src  = i;
                b.data = bus.req_data[8*i +: 8];
                b.last = l[i];
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(bus.out_src), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_src", 32'(bus.out_src), 32'(e.src));
                chk("out_data", 32'(bus.out_data), 32'(e.data));
                chk("out_last", 32'(bus.out_last), 32'(e.last));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b1;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_src", 32'(bus.out_src), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: all valid, single-beat bursts
        chk("t1_oval_pre", 32'(bus.out_valid), 0);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "t1_g0");
        chk("t1_oval_rise", 32'(bus.out_valid), 1);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, "t1_g1");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, "t1_g2");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, "t1_g3");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "t1_g0b");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, "t1_g1b");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "t1_idle");
        chk("t1_drained", 32'(bus.out_valid), 0);

        // Wrap and skip: bring ptr back to 0 via req3, then 0,3,0,3
        cyc(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, "t2_pre3");
        cyc(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b0, "t2_g0");
        cyc(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b0, "t2_g3");
        cyc(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b0, "t2_g0b");
        cyc(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b0, "t2_g3b");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "t2_idle");

        // Locked burst from req0 with req1 waiting, stalled mid-burst
        bus.req_data[7:0] = 8'h31;
        cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b0, "t3_b1");
        bus.req_data[7:0] = 8'h32;
        cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, "t3_b2");
        bus.req_data[7:0] = 8'h33;
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, "t3_stall1");
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, "t3_stall2");
        cyc(4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, "t3_b3");
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, "t3_req1");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "t3_idle");

        // Backpressure holds A5 for three cycles, then load on resume
        bus.req_data[23:16] = 8'hA5;
        bus.req_data[7:0]   = 8'h5A;
        cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, "t4_a5");
        for (int n = 0; n < 3; n++) begin
            cyc(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "t4_bp");
            chk("t4_hold_data", 32'(bus.out_data), 32'hA5);
            chk("t4_hold_valid", 32'(bus.out_valid), 1);
        end
        cyc(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, "t4_resume");
        chk("t4_valid_kept", 32'(bus.out_valid), 1);
        chk("t4_new_data", 32'(bus.out_data), 32'h5A);
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle");

        // Async reset while LOCKED
        cyc(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, "t5_burst");
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b0;
        #2;
        chk("t5_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_oval", 32'(bus.out_valid), 0);
        chk("t5_rst_ready", 32'(bus.req_ready), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, "t5_req2");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "t5_drain");
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "t5_ptr0");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "t5_idle");

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
